// File: rtl/led_strip_pkg.sv
// rtl/led_strip_pkg.sv - opcodes, mode/power enums and palette for the LED strip controller
package led_strip_pkg;

  localparam int PAL_SIZE = 16;
  localparam int PAL_CH_W = 32;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_FLASH   = 2'd1,
    MODE_RAINBOW = 2'd2
  } mode_e;

  typedef enum logic {
    PWR_OFF = 1'b0,
    PWR_ON  = 1'b1
  } pwr_e;

  typedef enum logic [3:0] {
    OP_NOP        = 4'd0,
    OP_POWER      = 4'd1,
    OP_MODE_NEXT  = 4'd2,
    OP_MODE_PREV  = 4'd3,
    OP_COLOR_NEXT = 4'd4,
    OP_COLOR_PREV = 4'd5,
    OP_BRI_UP     = 4'd6,
    OP_BRI_DOWN   = 4'd7,
    OP_SET_COLOR  = 4'd8
  } op_e;

  function automatic logic [23:0] palette24(input logic [3:0] idx);
    case (idx)
      4'd0:    return 24'hFF0000;
      4'd1:    return 24'hFF7F00;
      4'd2:    return 24'hFFFF00;
      4'd3:    return 24'h00FF00;
      4'd4:    return 24'h00FFFF;
      4'd5:    return 24'h0000FF;
      4'd6:    return 24'h4B0082;
      4'd7:    return 24'h8B00FF;
      4'd8:    return 24'hFFFFFF;
      4'd9:    return 24'hFF1493;
      4'd10:   return 24'h008080;
      4'd11:   return 24'h80FF00;
      4'd12:   return 24'h800080;
      4'd13:   return 24'hFFD700;
      4'd14:   return 24'h808080;
      default: return 24'h202020;
    endcase
  endfunction

  // Channels right-aligned at PAL_CH_W pitch, {R,G,B} high to low; 8-bit source
  // bits repeat from the MSB down so wide channels replicate and narrow ones truncate.
  function automatic logic [3*PAL_CH_W-1:0] palette_rgb(input logic [3:0] idx, input int cw);
    logic [23:0]             c24;
    logic [3*PAL_CH_W-1:0]   res;
    c24 = palette24(idx);
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      for (int b = 0; b < PAL_CH_W; b++) begin
        if (b < cw) res[ch*PAL_CH_W + cw - 1 - b] = c24[ch*8 + 7 - (b % 8)];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/led_pixel_scale.sv
// rtl/led_pixel_scale.sv - combinational one-pixel brightness scaler
// Scaling active only with LED_STRIP_BRI_SCALE_EN; otherwise a pass-through.
module led_pixel_scale #(
  parameter int CW    = 8,
  parameter int BRI_W = 3
) (
  input  logic [3*CW-1:0]  pix_i,
  input  logic [BRI_W-1:0] bri_i,
  output logic [3*CW-1:0]  pix_o
);

`ifdef LED_STRIP_BRI_SCALE_EN
  logic [BRI_W:0] gain;
  assign gain = {1'b0, bri_i} + (BRI_W+1)'(1);

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    logic [CW+BRI_W-1:0] prod;
    assign prod = (CW+BRI_W)'(pix_i[ch*CW +: CW]) * (CW+BRI_W)'(gain);
    assign pix_o[ch*CW +: CW] = CW'(prod >> BRI_W);
  end
`else
  logic unused_bri;
  assign unused_bri = ^bri_i;
  assign pix_o      = pix_i;
`endif

endmodule

// File: rtl/led_strip_ctrl.sv
// rtl/led_strip_ctrl.sv - opcode-driven LED strip controller (power/mode/colour/brightness, flash, rainbow)
// Optional per-channel brightness scaling: LED_STRIP_BRI_SCALE_EN
module led_strip_ctrl
  import led_strip_pkg::*;
#(
  parameter int N_LEDS    = 10,
  parameter int CW        = 8,
  parameter int N_COLORS  = 8,
  parameter int BRI_W     = 3,
  parameter int FLASH_DIV = 4,
  parameter int ROT_DIV   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        op_valid,
  input  logic [3:0]                  op_code,
  output logic                        sys_on,
  output logic [1:0]                  mode,
  output logic [$clog2(N_COLORS)-1:0] color_idx,
  output logic [BRI_W-1:0]            brightness,
  output logic [N_LEDS*3*CW-1:0]      strip
);

  localparam int CIW = $clog2(N_COLORS);
  localparam int PW  = 3*CW;
  localparam int FCW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam int RCW = (ROT_DIV > 1) ? $clog2(ROT_DIV) : 1;
  localparam logic [FCW-1:0]   FLASH_LAST = FCW'(FLASH_DIV - 1);
  localparam logic [RCW-1:0]   ROT_LAST   = RCW'(ROT_DIV - 1);
  localparam logic [CIW-1:0]   COLOR_LAST = CIW'(N_COLORS - 1);
  localparam logic [BRI_W-1:0] BRI_MAX    = '1;

  pwr_e             pwr_q;
  mode_e            mode_q;
  logic [CIW-1:0]   color_q, hist_q, rot_ptr_q;
  logic [BRI_W-1:0] bri_q;
  logic [FCW-1:0]   flash_cnt_q;
  logic             flash_lit_q;
  logic [RCW-1:0]   rot_cnt_q;
  logic [N_LEDS*PW-1:0] strip_q, strip_d;

  logic           op_power, op_mode_chg, set_ok;
  logic [CIW-1:0] set_idx;

  assign op_power    = op_valid && (op_code == OP_POWER);
  assign op_mode_chg = op_valid && (op_code == OP_MODE_NEXT || op_code == OP_MODE_PREV);
  assign set_idx     = CIW'(op_code[2:0]);
  assign set_ok      = (32'(op_code[2:0]) < 32'(N_COLORS)) && (set_idx != color_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwr_q       <= PWR_OFF;
      mode_q      <= MODE_SOLID;
      color_q     <= '0;
      hist_q      <= '0;
      bri_q       <= BRI_MAX;
      rot_ptr_q   <= '0;
      rot_cnt_q   <= '0;
      flash_cnt_q <= '0;
      flash_lit_q <= 1'b1;
    end else begin
      case (pwr_q)
        PWR_OFF: begin
          flash_cnt_q <= '0;
          flash_lit_q <= 1'b1;
          if (op_power) begin
            pwr_q     <= PWR_ON;
            mode_q    <= MODE_SOLID;
            color_q   <= '0;
            hist_q    <= '0;
            bri_q     <= BRI_MAX;
            rot_ptr_q <= '0;
            rot_cnt_q <= '0;
          end
        end
        default: begin
          if (op_power) begin
            pwr_q       <= PWR_OFF;
            flash_cnt_q <= '0;
            flash_lit_q <= 1'b1;
          end else begin
            // A mode change overrides any timer wrap in the same cycle.
            if (op_mode_chg) begin
              flash_cnt_q <= '0;
              flash_lit_q <= 1'b1;
              rot_cnt_q   <= '0;
              rot_ptr_q   <= '0;
            end else begin
              if (mode_q == MODE_FLASH) begin
                if (flash_cnt_q == FLASH_LAST) begin
                  flash_cnt_q <= '0;
                  flash_lit_q <= ~flash_lit_q;
                end else begin
                  flash_cnt_q <= flash_cnt_q + FCW'(1);
                end
              end
              if (mode_q == MODE_RAINBOW) begin
                if (rot_cnt_q == ROT_LAST) begin
                  rot_cnt_q <= '0;
                  rot_ptr_q <= (rot_ptr_q == COLOR_LAST) ? '0 : rot_ptr_q + CIW'(1);
                end else begin
                  rot_cnt_q <= rot_cnt_q + RCW'(1);
                end
              end
            end
            if (op_valid) begin
              casez (op_code)
                OP_MODE_NEXT: mode_q <= (mode_q == MODE_RAINBOW) ? MODE_SOLID : mode_e'(mode_q + 2'd1);
                OP_MODE_PREV: mode_q <= (mode_q == MODE_SOLID) ? MODE_RAINBOW : mode_e'(mode_q - 2'd1);
                OP_COLOR_NEXT: begin
                  hist_q  <= color_q;
                  color_q <= (color_q == COLOR_LAST) ? '0 : color_q + CIW'(1);
                end
                OP_COLOR_PREV: begin
                  hist_q  <= color_q;
                  color_q <= hist_q;
                end
                OP_BRI_UP:   if (bri_q != BRI_MAX) bri_q <= bri_q + BRI_W'(1);
                OP_BRI_DOWN: if (bri_q != '0) bri_q <= bri_q - BRI_W'(1);
                4'b1???: if (set_ok) begin
                  hist_q  <= color_q;
                  color_q <= set_idx;
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  logic [N_COLORS-1:0][3*PAL_CH_W-1:0] pal_wide;
  logic [PW-1:0] pal_pix    [N_COLORS];
  logic [PW-1:0] base_pix   [N_LEDS];
  logic [PW-1:0] scaled_pix [N_LEDS];
  logic          unused_pal;

  always_comb begin
    for (int c = 0; c < N_COLORS; c++) begin
      pal_wide[c] = palette_rgb(4'(c), CW);
      pal_pix[c]  = {pal_wide[c][2*PAL_CH_W +: CW], pal_wide[c][PAL_CH_W +: CW], pal_wide[c][0 +: CW]};
    end
  end
  assign unused_pal = ^pal_wide;

  always_comb begin
    for (int i = 0; i < N_LEDS; i++) begin
      if (mode_q == MODE_RAINBOW)
        base_pix[i] = pal_pix[CIW'((32'(i) + 32'(rot_ptr_q) + 32'(color_q)) % 32'(N_COLORS))];
      else
        base_pix[i] = pal_pix[color_q];
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_pix
    led_pixel_scale #(.CW(CW), .BRI_W(BRI_W)) u_scale (
      .pix_i (base_pix[i]),
      .bri_i (bri_q),
      .pix_o (scaled_pix[i])
    );
  end

  // flash_lit_q is held at 1 outside FLASH, so it only blanks the unlit half.
  always_comb begin
    strip_d = '0;
    if (pwr_q == PWR_ON && flash_lit_q) begin
      for (int i = 0; i < N_LEDS; i++) strip_d[i*PW +: PW] = scaled_pix[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) strip_q <= '0;
    else        strip_q <= strip_d;
  end

  assign sys_on     = (pwr_q == PWR_ON);
  assign mode       = mode_q;
  assign color_idx  = color_q;
  assign brightness = bri_q;
  assign strip      = strip_q;

endmodule

// File: tb/tb_led_strip_ctrl.sv
// tb/tb_led_strip_ctrl.sv - self-checking bench for led_strip_ctrl (default parameters)
module tb_led_strip_ctrl;

  localparam int NL = 10;
  localparam int SW = NL*24;

  logic          clk, rst_n, op_valid;
  logic [3:0]    op_code;
  logic          sys_on;
  logic [1:0]    mode;
  logic [2:0]    color_idx;
  logic [2:0]    brightness;
  logic [SW-1:0] strip;

  led_strip_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .op_code    (op_code),
    .sys_on     (sys_on),
    .mode       (mode),
    .color_idx  (color_idx),
    .brightness (brightness),
    .strip      (strip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       v;
    logic [3:0] op;
    logic       on;
    logic [1:0] md;
    logic [2:0] col;
    logic [2:0] bri;
  } vec_t;

  vec_t          tbl [24];
  logic [SW-1:0] sb_q [$];
  logic [SW-1:0] exp_s;

  function automatic logic [23:0] pal(input int c);
    case (c)
      0: return 24'hFF0000;  1: return 24'hFF7F00;  2: return 24'hFFFF00;  3: return 24'h00FF00;
      4: return 24'h00FFFF;  5: return 24'h0000FF;  6: return 24'h4B0082;  7: return 24'h8B00FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] exp_pix(input int c, input int b);
    logic [23:0] rgb;
    rgb = pal(c);
`ifdef LED_STRIP_BRI_SCALE_EN
    for (int ch = 0; ch < 3; ch++) rgb[ch*8 +: 8] = 8'((int'(rgb[ch*8 +: 8]) * (b + 1)) >> 3);
`endif
    return rgb;
  endfunction

  function automatic logic [SW-1:0] exp_solid(input int c, input int b);
    logic [SW-1:0] s;
    for (int i = 0; i < NL; i++) s[i*24 +: 24] = exp_pix(c, b);
    return s;
  endfunction

  function automatic logic [SW-1:0] exp_rainbow(input int c, input int ptr);
    logic [SW-1:0] s;
    for (int i = 0; i < NL; i++) s[i*24 +: 24] = exp_pix((i + ptr + c) % 8, 7);
    return s;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic v, input logic [3:0] op);
    op_valid = v;
    op_code  = op;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_code  = 4'd0;
  endtask

  task automatic chk_status(input string nm, input logic on, input logic [1:0] md,
                            input logic [2:0] col, input logic [2:0] bri);
    chk({nm, ".sys_on"}, sys_on, on);
    chk({nm, ".mode"}, mode, md);
    chk({nm, ".color"}, color_idx, col);
    chk({nm, ".bri"}, brightness, bri);
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; op_code = 4'd0;
    tbl[0]  = '{1'b1, 4'h4, 1'b0, 2'd0, 3'd0, 3'd7};
    tbl[1]  = '{1'b1, 4'h2, 1'b0, 2'd0, 3'd0, 3'd7};
    tbl[2]  = '{1'b1, 4'h1, 1'b1, 2'd0, 3'd0, 3'd7};
    tbl[3]  = '{1'b1, 4'h0, 1'b1, 2'd0, 3'd0, 3'd7};
    tbl[4]  = '{1'b1, 4'h4, 1'b1, 2'd0, 3'd1, 3'd7};
    tbl[5]  = '{1'b1, 4'h4, 1'b1, 2'd0, 3'd2, 3'd7};
    tbl[6]  = '{1'b1, 4'h5, 1'b1, 2'd0, 3'd1, 3'd7};
    tbl[7]  = '{1'b1, 4'h5, 1'b1, 2'd0, 3'd2, 3'd7};
    tbl[8]  = '{1'b1, 4'hA, 1'b1, 2'd0, 3'd2, 3'd7};
    tbl[9]  = '{1'b1, 4'hF, 1'b1, 2'd0, 3'd7, 3'd7};
    tbl[10] = '{1'b0, 4'h4, 1'b1, 2'd0, 3'd7, 3'd7};
    tbl[11] = '{1'b1, 4'h5, 1'b1, 2'd0, 3'd2, 3'd7};
    tbl[12] = '{1'b1, 4'h5, 1'b1, 2'd0, 3'd7, 3'd7};
    tbl[13] = '{1'b1, 4'h6, 1'b1, 2'd0, 3'd7, 3'd7};
    tbl[14] = '{1'b1, 4'h7, 1'b1, 2'd0, 3'd7, 3'd6};
    tbl[15] = '{1'b1, 4'h7, 1'b1, 2'd0, 3'd7, 3'd5};
    tbl[16] = '{1'b1, 4'h6, 1'b1, 2'd0, 3'd7, 3'd6};
    tbl[17] = '{1'b1, 4'h4, 1'b1, 2'd0, 3'd0, 3'd6};
    tbl[18] = '{1'b1, 4'h5, 1'b1, 2'd0, 3'd7, 3'd6};
    tbl[19] = '{1'b1, 4'h8, 1'b1, 2'd0, 3'd0, 3'd6};
    tbl[20] = '{1'b1, 4'h1, 1'b0, 2'd0, 3'd0, 3'd6};
    tbl[21] = '{1'b1, 4'h5, 1'b0, 2'd0, 3'd0, 3'd6};
    tbl[22] = '{1'b1, 4'h1, 1'b1, 2'd0, 3'd0, 3'd7};
    tbl[23] = '{1'b1, 4'h5, 1'b1, 2'd0, 3'd0, 3'd7};

    repeat (2) @(posedge clk);
    #1;
    chk_status("reset", 1'b0, 2'd0, 3'd0, 3'd7);
    chk("reset.strip", strip, '0);
    rst_n = 1'b1;

    for (int j = 0; j < 24; j++) begin
      sb_q.push_back(tbl[j].on ? exp_solid(int'(tbl[j].col), int'(tbl[j].bri)) : '0);
      tick(tbl[j].v, tbl[j].op);
      chk_status($sformatf("vec%0d", j), tbl[j].on, tbl[j].md, tbl[j].col, tbl[j].bri);
      if (sb_q.size() > 1) begin
        exp_s = sb_q.pop_front();
        chk($sformatf("vec%0d.strip", j), strip, exp_s);
      end
    end

    tick(1'b1, 4'd2);
    chk("flash.mode", mode, 2'd1);
    for (int n = 1; n <= 16; n++) begin
      tick(1'b0, 4'd0);
      exp_s = (((n - 1) / 4) % 2 == 0) ? exp_solid(0, 7) : '0;
      chk($sformatf("flash.strip%0d", n), strip, exp_s);
    end
    tick(1'b1, 4'd3);
    chk("flash_exit.mode", mode, 2'd0);
    for (int n = 0; n < 2; n++) begin
      tick(1'b0, 4'd0);
      chk("solid_after_flash.strip", strip, exp_solid(0, 7));
    end

    tick(1'b1, 4'd3);
    chk("mode_prev_wrap", mode, 2'd2);
    tick(1'b1, 4'd2);
    chk("mode_next_wrap", mode, 2'd0);
    tick(1'b1, 4'hB);
    chk("set_color3", color_idx, 3'd3);
    tick(1'b1, 4'd2);
    tick(1'b1, 4'd2);
    chk("rainbow.mode", mode, 2'd2);
    for (int n = 1; n <= 35; n++) begin
      tick(1'b0, 4'd0);
      if (n inside {1, 4, 5, 8, 9, 32, 33})
        chk($sformatf("rainbow.strip%0d", n), strip, exp_rainbow(3, ((n - 1) / 4) % 8));
    end

    #3 rst_n = 1'b0;
    #1;
    chk_status("async_reset", 1'b0, 2'd0, 3'd0, 3'd7);
    chk("async_reset.strip", strip, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1'b1, 4'd2);
    chk_status("off_ignore_mode", 1'b0, 2'd0, 3'd0, 3'd7);
    tick(1'b1, 4'hF);
    chk_status("off_ignore_set", 1'b0, 2'd0, 3'd0, 3'd7);
    tick(1'b0, 4'd0);
    chk("off.strip", strip, '0);

    tick(1'b1, 4'd1);
    repeat (8) tick(1'b1, 4'd7);
    chk("bri_floor", brightness, 3'd0);
    tick(1'b0, 4'd0);
    chk("bri0.strip", strip, exp_solid(0, 0));
    repeat (9) tick(1'b1, 4'd6);
    chk("bri_ceiling", brightness, 3'd7);
    tick(1'b0, 4'd0);
    chk("bri7.strip", strip, exp_solid(0, 7));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
